// File: rtl/store_trace_checker.sv
// Store-bus checker: traces every CPU store into a FIFO and decides
// PASS/FAIL/TIMEOUT from the store stream.
module store_trace_checker #(
  parameter int unsigned DEPTH          = 16,
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADDR     = 32'd80,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic [31:0]              pc,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 96;

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cyc_q;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic            full_c, pop_c, store_c, push_c, drop_c;

  // Next-state and FIFO handshake decode
  always_comb begin
    state_d = state_q;
    pop_c   = rd_en && (count != '0);
    full_c  = (count == CW'(DEPTH));
    store_c = (state_q == S_RUN) && memwrite;
    push_c  = store_c && (!full_c || pop_c);
    drop_c  = store_c && full_c && !pop_c;
    case (state_q)
      S_RUN: begin
        if (memwrite && (dataadr == PASS_ADDR) && (writedata == PASS_DATA)) begin
          state_d = S_PASS;
        end else if (memwrite && (dataadr != ALLOW_ADDR)) begin
          state_d = S_FAIL;
        end else if (cyc_q == 32'(TIMEOUT_CYCLES - 32'd1)) begin
          state_d = S_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State, counters, readout and registered status decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      cyc_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_addr  <= '0;
      rd_data  <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RUN) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (push_c) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_c) begin
        rptr_q <= rptr_q + AW'(1);
        {rd_pc, rd_addr, rd_data} <= mem[rptr_q];
      end
      if (push_c && !pop_c) begin
        count <= count + CW'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CW'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
      rd_valid <= pop_c;
      done     <= (state_d != S_RUN);
      pass     <= (state_d == S_PASS);
      fail     <= (state_d == S_FAIL);
      timeout  <= (state_d == S_TIMEOUT);
    end
  end

  // Trace storage; a full-and-popping write lands on the slot being read out
  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      mem[wptr_q] <= {pc, dataadr, writedata};
    end
  end

endmodule
